// File: rtl/spwtcr_pkg.sv
// Shared types and constants for the SpaceWire link-interface controller.
// The link-state encoding is visible on the linkState port.
package spwtcr_pkg;

    typedef enum logic [2:0] {
        ERROR_RESET = 3'd0,
        ERROR_WAIT  = 3'd1,
        READY       = 3'd2,
        STARTED     = 3'd3,
        CONNECTING  = 3'd4,
        RUN         = 3'd5
    } link_state_t;

    // enableTimer is held low this many clocks after every state change
    localparam int unsigned TIMER_GAP_CLK = 1;
    localparam int unsigned TIMER_GAP_W   = $clog2(TIMER_GAP_CLK + 1);

    // States in which the shared 6.4/12.8 us timer runs
    function automatic logic is_timed(input link_state_t s);
        return (s == ERROR_RESET) || (s == ERROR_WAIT) ||
               (s == STARTED)     || (s == CONNECTING);
    endfunction

endpackage

// File: rtl/spwtcr_link_ctrl.sv
// SpaceWire link-interface state machine: sequences codec RX/TX from ErrorReset to Run
// and drives the external FSM timer. Outputs are registered and decoded from next state.
module spwtcr_link_ctrl
    import spwtcr_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic       linkStart,
    input  logic       autoStart,
    input  logic       linkDisable,
    input  logic       gotNULL,
    input  logic       gotFCT,
    input  logic       gotNChar,
    input  logic       gotTimeCode,
    input  logic       disconnErr,
    input  logic       parityErr,
    input  logic       escapeErr,
    input  logic       creditErr,
    input  logic       after64,
    input  logic       after128,
    output logic       enableTimer,
    output logic       rxEnable,
    output logic       txEnable,
    output logic       sendNULLs,
    output logic       sendFCTs,
    output logic       sendNChars,
    output logic [2:0] linkState,
    output logic       linkErrPulse
);

    link_state_t            state_q, state_d;
    logic                   null_seen_q, null_seen_d;
    logic [TIMER_GAP_W-1:0] gap_q, gap_d;

    logic err, proto, link_en, err_exit;
    logic enable_timer_d, rx_d, tx_d, nulls_d, fcts_d, nchars_d;

    // Next-state and registered-output decode
    always_comb begin
        err      = disconnErr | parityErr | escapeErr;
        proto    = gotFCT | gotNChar | gotTimeCode;
        link_en  = !linkDisable && (linkStart || (autoStart && (null_seen_q || gotNULL)));
        state_d  = state_q;
        err_exit = 1'b0;

        // Error and timeout exits take priority over any advance in the same cycle
        case (state_q)
            ERROR_RESET: begin
                if (after64) state_d = ERROR_WAIT;
            end
            ERROR_WAIT: begin
                if (err || proto) begin
                    state_d  = ERROR_RESET;
                    err_exit = 1'b1;
                end else if (after128) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (err || proto) begin
                    state_d  = ERROR_RESET;
                    err_exit = 1'b1;
                end else if (link_en) begin
                    state_d = STARTED;
                end
            end
            STARTED: begin
                if (after128 || err || proto) begin
                    state_d  = ERROR_RESET;
                    err_exit = 1'b1;
                end else if (null_seen_q || gotNULL) begin
                    state_d = CONNECTING;
                end
            end
            CONNECTING: begin
                if (after128 || err || gotNChar || gotTimeCode) begin
                    state_d  = ERROR_RESET;
                    err_exit = 1'b1;
                end else if (gotFCT) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (err || creditErr) begin
                    state_d  = ERROR_RESET;
                    err_exit = 1'b1;
                end else if (linkDisable) begin
                    state_d = ERROR_RESET;
                end
            end
            default: state_d = ERROR_RESET;
        endcase

        null_seen_d = null_seen_q;
        if (state_d == ERROR_RESET) begin
            null_seen_d = 1'b0;
        end else if (gotNULL && ((state_q == ERROR_WAIT) || (state_q == READY) ||
                                 (state_q == STARTED))) begin
            null_seen_d = 1'b1;
        end

        // Restart gap so each timed state counts from zero
        if (state_d != state_q) begin
            gap_d = TIMER_GAP_W'(TIMER_GAP_CLK);
        end else if (gap_q != '0) begin
            gap_d = gap_q - TIMER_GAP_W'(1);
        end else begin
            gap_d = '0;
        end

        enable_timer_d = is_timed(state_d) && (gap_d == '0);
        rx_d           = (state_d != ERROR_RESET);
        tx_d           = (state_d == STARTED) || (state_d == CONNECTING) || (state_d == RUN);
        nulls_d        = tx_d;
        fcts_d         = (state_d == CONNECTING) || (state_d == RUN);
        nchars_d       = (state_d == RUN);
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= ERROR_RESET;
            null_seen_q  <= 1'b0;
            gap_q        <= '0;
            enableTimer  <= 1'b0;
            rxEnable     <= 1'b0;
            txEnable     <= 1'b0;
            sendNULLs    <= 1'b0;
            sendFCTs     <= 1'b0;
            sendNChars   <= 1'b0;
            linkErrPulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            null_seen_q  <= null_seen_d;
            gap_q        <= gap_d;
            enableTimer  <= enable_timer_d;
            rxEnable     <= rx_d;
            txEnable     <= tx_d;
            sendNULLs    <= nulls_d;
            sendFCTs     <= fcts_d;
            sendNChars   <= nchars_d;
            linkErrPulse <= err_exit;
        end
    end

    assign linkState = state_q;

endmodule
